fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter XLEN, default 32: address and instruction width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_addr  output  XLEN  fetch address to InstMem addr.
REQ-006 SHALL have port imem_rdata  input  XLEN  InstMem dout, combinational from imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect strobe.
REQ-008 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-009 SHALL have port halt_req  input  1  stop issuing new fetches.
REQ-010 SHALL have port resume  input  1  restart fetching from HALT.
REQ-011 SHALL have port out_valid  output  1  instruction available to decode.
REQ-012 SHALL have port out_ready  input  1  decode accepts the instruction.
REQ-013 SHALL have port out_pc  output  XLEN  PC of the head instruction.
REQ-014 SHALL have port out_instr  output  XLEN  head instruction word.
REQ-015 SHALL have port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 HALT.

Function
REQ-016 SHALL hold a fetch PC register; imem_addr SHALL equal the PC combinationally at all times.
REQ-017 SHALL contain a 2-entry FIFO of {pc, instr}; out_valid = (count != 0); out_pc/out_instr = head entry.
REQ-018 SHALL pop the head on a cycle where out_valid && out_ready.
REQ-019 SHALL push {PC, imem_rdata} and advance PC by 4 on a cycle where state==RUN, no redirect_valid, no halt_req, and (count<2 or a pop occurs that cycle).
REQ-020 SHALL not push or advance PC when the FIFO is full and no pop occurs (fetch stall, PC held).
REQ-021 SHALL wrap PC modulo 2^XLEN: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
REQ-022 SHALL on redirect_valid (any state except IDLE) flush the FIFO (count->0, including any same-cycle pop), load PC with {redirect_pc[XLEN-1:2], 2'b00}, and perform no push that cycle.
REQ-023 FSM transitions: IDLE -> RUN unconditionally after one cycle; RUN -> HALT on halt_req; HALT -> RUN on resume with halt_req low; otherwise hold.
REQ-024 SHALL give halt_req priority over resume when both are high (stay or enter HALT).
REQ-025 SHALL apply redirect and halt_req together when simultaneous: flush, load PC, enter HALT.
REQ-026 In HALT, the FIFO SHALL continue to drain via out_ready; redirect SHALL update PC and flush, and the state SHALL remain HALT.
REQ-027 SHALL ignore redirect_valid, halt_req and resume in IDLE.
REQ-028 Latency: an instruction fetched on edge N SHALL appear at out_* immediately after edge N; first out_valid=1 after the second rising edge following rst_n deassertion.
REQ-029 out_pc/out_instr SHALL remain stable while out_valid && !out_ready.

Reset
REQ-030 On rst_n low (asynchronous, mid-operation included): PC=RESET_PC, state=IDLE, count=0, out_valid=0, out_pc=0, out_instr=0; FIFO contents discarded.
REQ-031 After rst_n rises, the block SHALL behave per REQ-023 starting from IDLE on the next rising edge.

Verification
REQ-032 Reset release, out_ready=1, InstMem preloaded -> out_pc sequence 0,4,8,...,28,32 with out_instr matching memory words; first valid after 2nd edge.
REQ-033 out_ready=0 for 5 cycles from reset -> FIFO holds PC 0 and 4, imem_addr stuck at 8, out_pc=0 stable; then out_ready=1 -> 0,4,8 delivered with no gap or duplicate.
REQ-034 redirect_valid with redirect_pc=32'h0000_0033 while FIFO holds 2 entries -> out_valid=0 next cycle, PC=32'h30, next out_pc=32'h30.
REQ-035 halt_req at PC=16 with FIFO full, out_ready=1 -> state=HALT, 2 buffered entries drain, no further fetch, imem_addr=16; resume -> RUN, out_pc continues 16.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 rst_n pulsed low mid-stream with FIFO full -> outputs zero immediately (before next edge); restart from RESET_PC per REQ-032.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives InstMem from a PC register and buffers
// fetched {pc, instr} pairs in a 2-entry FIFO toward decode.
module fetch_ctrl #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  input  logic            resume,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      count_q, count_d;
  logic            head_q, head_d;
  logic [XLEN-1:0] fifo_pc_q [2];
  logic [XLEN-1:0] fifo_pc_d [2];
  logic [XLEN-1:0] fifo_instr_q [2];
  logic [XLEN-1:0] fifo_instr_d [2];

  logic pop, push, redir, tail;
  logic redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign pop   = (count_q != 2'd0) && out_ready;
  assign redir = redirect_valid && (state_q != ST_IDLE);
  assign push  = (state_q == ST_RUN) && !redirect_valid && !halt_req &&
                 ((count_q != 2'd2) || pop);
  // Tail slot sits opposite the head only when exactly one entry is held.
  assign tail  = head_q ^ (count_q == 2'd1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    head_d       = head_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;

    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  if (halt_req) state_d = ST_HALT;
      ST_HALT: if (resume && !halt_req) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase

    if (redir) begin
      // A redirect discards everything buffered, including a same-cycle pop.
      count_d = 2'd0;
      head_d  = 1'b0;
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (push) begin
        fifo_pc_d[tail]    = pc_q;
        fifo_instr_d[tail] = imem_rdata;
        pc_d               = pc_q + XLEN'(4);
      end
      if (pop) head_d = ~head_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      head_q       <= 1'b0;
      fifo_pc_q    <= '{default: '0};
      fifo_instr_q <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      head_q       <= head_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  // Outputs read zero when empty so reset and flush both present a clean bus.
  assign out_pc    = out_valid ? fifo_pc_q[head_q]    : '0;
  assign out_instr = out_valid ? fifo_instr_q[head_q] : '0;
  assign state     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a default-reset instance plus one reset near
// the top of the address space to exercise PC wrap.
module tb_fetch_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] imem_addr, imem_rdata, imem_addr2, imem_rdata2;
  logic            redirect_valid, halt_req, resume, out_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid, out_valid2;
  logic [XLEN-1:0] out_pc, out_instr, out_pc2, out_instr2;
  logic [1:0]      state, state2;

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata  = mem[imem_addr[7:2]];
  assign imem_rdata2 = mem[imem_addr2[7:2]];

  fetch_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .resume(resume), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .state(state)
  );

  fetch_ctrl #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .resume(resume), .out_valid(out_valid2),
    .out_ready(out_ready), .out_pc(out_pc2), .out_instr(out_instr2), .state(state2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; resume = 1'b0; out_ready = 1'b0;
    step; step;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; resume = 1'b0; out_ready = 1'b0;
    step;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    checks++; if (imem_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_pc_param got %h want fffffff8", imem_addr2); end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_stream;
    apply_reset;
    out_ready = 1'b1;
    step;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL stream_run got %b want 01", state); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_first_edge_valid got %b want 0", out_valid); end
    for (int k = 0; k < 9; k++) begin
      step;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
        errors++; $display("FAIL stream_pc[%0d] got v=%b pc=%h want v=1 pc=%h", k, out_valid, out_pc, 32'(4 * k));
      end
      checks++; if (out_instr !== mem[k]) begin
        errors++; $display("FAIL stream_instr[%0d] got %h want %h", k, out_instr, mem[k]);
      end
    end
    $display("test_stream done");
  endtask

  task automatic test_stall;
    apply_reset;
    for (int k = 0; k < 5; k++) begin
      step;
      if (k >= 1) begin
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
          errors++; $display("FAIL stall_hold[%0d] got v=%b pc=%h want v=1 pc=0", k, out_valid, out_pc);
        end
      end
    end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_addr got %h want 8", imem_addr); end
    out_ready = 1'b1;
    step;
    checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL stall_drain1 got %h want 4", out_pc); end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr2 got %h want c", imem_addr); end
    step;
    checks++; if (out_pc !== 32'h8 || out_instr !== mem[2]) begin
      errors++; $display("FAIL stall_drain2 got pc=%h instr=%h want pc=8 instr=%h", out_pc, out_instr, mem[2]);
    end
    $display("test_stall done");
  endtask

  task automatic test_redirect;
    apply_reset;
    step; step; step;
    checks++; if (out_pc !== 32'h0 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL redir_setup got pc=%h addr=%h want pc=0 addr=8", out_pc, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0033; out_ready = 1'b1;
    step;
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", out_valid); end
    checks++; if (imem_addr !== 32'h30) begin errors++; $display("FAIL redir_pc got %h want 30", imem_addr); end
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h30 || out_instr !== mem[12]) begin
      errors++; $display("FAIL redir_next got v=%b pc=%h instr=%h want v=1 pc=30 instr=%h", out_valid, out_pc, out_instr, mem[12]);
    end
    $display("test_redirect done");
  endtask

  task automatic test_halt;
    apply_reset;
    step; step; step;
    out_ready = 1'b1;
    step; step;
    checks++; if (out_pc !== 32'h8 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL halt_setup got pc=%h addr=%h want pc=8 addr=10", out_pc, imem_addr);
    end
    halt_req = 1'b1;
    step;
    halt_req = 1'b0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL halt_enter got %b want 10", state); end
    checks++; if (out_pc !== 32'hC || imem_addr !== 32'h10) begin
      errors++; $display("FAIL halt_drain1 got pc=%h addr=%h want pc=c addr=10", out_pc, imem_addr);
    end
    step;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h10 || state !== 2'b10) begin
      errors++; $display("FAIL halt_drained got v=%b addr=%h st=%b want v=0 addr=10 st=10", out_valid, imem_addr, state);
    end
    resume = 1'b1;
    step;
    resume = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL halt_resume got %b want 01", state); end
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin
      errors++; $display("FAIL halt_continue got v=%b pc=%h want v=1 pc=10", out_valid, out_pc);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0041; halt_req = 1'b1;
    step;
    checks++; if (state !== 2'b10 || out_valid !== 1'b0 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL halt_redir_combo got st=%b v=%b addr=%h want st=10 v=0 addr=40", state, out_valid, imem_addr);
    end
    halt_req = 1'b0; redirect_pc = 32'h0000_0080;
    step;
    redirect_valid = 1'b0;
    checks++; if (state !== 2'b10 || imem_addr !== 32'h80) begin
      errors++; $display("FAIL halt_redir_in_halt got st=%b addr=%h want st=10 addr=80", state, imem_addr);
    end
    halt_req = 1'b1; resume = 1'b1;
    step;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL halt_priority got %b want 10", state); end
    halt_req = 1'b0;
    step;
    resume = 1'b0;
    step;
    checks++; if (state !== 2'b01 || out_pc !== 32'h80 || out_instr !== mem[32]) begin
      errors++; $display("FAIL halt_redir_resume got st=%b pc=%h instr=%h want st=01 pc=80 instr=%h", state, out_pc, out_instr, mem[32]);
    end
    $display("test_halt done");
  endtask

  task automatic test_wrap;
    logic [31:0] wexp [3];
    int          widx [3];
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    widx = '{62, 63, 0};
    apply_reset;
    out_ready = 1'b1;
    step;
    for (int k = 0; k < 3; k++) begin
      step;
      checks++; if (out_valid2 !== 1'b1 || out_pc2 !== wexp[k] || out_instr2 !== mem[widx[k]]) begin
        errors++; $display("FAIL wrap[%0d] got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                           k, out_valid2, out_pc2, out_instr2, wexp[k], mem[widx[k]]);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_async_reset;
    apply_reset;
    step; step; step;
    checks++; if (out_valid !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL areset_setup got v=%b addr=%h want v=1 addr=8", out_valid, imem_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++; $display("FAIL areset_outputs got v=%b pc=%h instr=%h want all 0", out_valid, out_pc, out_instr);
    end
    checks++; if (state !== 2'b00 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL areset_state got st=%b addr=%h want st=00 addr=0", state, imem_addr);
    end
    step;
    rst_n = 1'b1; out_ready = 1'b1;
    step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_edge1 got %b want 0", out_valid); end
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL areset_restart got v=%b pc=%h want v=1 pc=0", out_valid, out_pc);
    end
    step;
    checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL areset_next got %h want 4", out_pc); end
    $display("test_async_reset done");
  endtask

  task automatic test_idle_ignore;
    apply_reset;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; halt_req = 1'b1; resume = 1'b1;
    step;
    redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
    checks++; if (state !== 2'b01 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL idle_ignore got st=%b addr=%h want st=01 addr=0", state, imem_addr);
    end
    step;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL idle_first got v=%b pc=%h want v=1 pc=0", out_valid, out_pc);
    end
    $display("test_idle_ignore done");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 17);
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_halt;
    test_wrap;
    test_async_reset;
    test_idle_ignore;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
